// File: rtl/data_mem_responder_if.sv
// Refill/store bus between a cache requester and the data memory responder.
// MEM_RESP_RANGE_CHECK_EN adds the mem_err response line.
interface data_mem_responder_if;
   logic         mem_rd_en;
   logic [31:0]  mem_rd_addr;
   logic         mem_wr_en;
   logic [31:0]  mem_wr_addr;
   logic [31:0]  mem_wr_data;
   logic [1:0]   mem_wr_sel;
   logic [127:0] mem_rd_data;
   logic         mem_rd_valid;
   logic         mem_busy;
`ifdef MEM_RESP_RANGE_CHECK_EN
   logic         mem_err;

   modport master (
      output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_sel,
      input  mem_rd_data, mem_rd_valid, mem_busy, mem_err
   );
   modport slave (
      input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_sel,
      output mem_rd_data, mem_rd_valid, mem_busy, mem_err
   );
`else
   modport master (
      output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_sel,
      input  mem_rd_data, mem_rd_valid, mem_busy
   );
   modport slave (
      input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_sel,
      output mem_rd_data, mem_rd_valid, mem_busy
   );
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed backing store answering 16-byte line refills after a fixed latency and
// accepting byte/half/word stores while idle. MEM_RESP_RANGE_CHECK_EN adds range checking.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned RD_LATENCY  = 4
) (
   input logic                 clk,
   input logic                 rst,
   data_mem_responder_if.slave bus
);
   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [1:0]  IDLE     = 2'd0;
   localparam logic [1:0]  RD_WAIT  = 2'd1;
   localparam logic [1:0]  RD_RESP  = 2'd2;
   localparam logic [3:0]  CNT_INIT = 4'(RD_LATENCY - 1);

   logic [31:0]   mem [DEPTH_WORDS];

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] base_q, base_d;
   logic [127:0]  rd_data_q;

   logic          idle, load_line, line_oor;
   logic [AW-1:0] req_base, line_base;
   logic [127:0]  rd_line;

   logic [AW-1:0] wr_idx;
   logic [3:0]    wr_be;
   logic [31:0]   wr_lanes;
   logic          wr_req, wr_oor, wr_go;

   assign idle      = (state_q == IDLE);
   assign req_base  = bus.mem_rd_addr[AW+1:2] & ~AW'(3);
   // A latency-1 read loads straight from IDLE, so it must see the incoming address.
   assign line_base = idle ? req_base : base_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      base_d    = base_q;
      load_line = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.mem_rd_en) begin
               base_d = req_base;
               cnt_d  = CNT_INIT;
               if (RD_LATENCY == 1) begin
                  state_d   = RD_RESP;
                  load_line = 1'b1;
               end else begin
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d   = RD_RESP;
               load_line = 1'b1;
            end
         end
         RD_RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Store lane decode; data is right-justified so it is replicated across lanes.
   assign wr_idx = bus.mem_wr_addr[AW+1:2];
   always_comb begin
      wr_be    = 4'b0000;
      wr_lanes = bus.mem_wr_data;
      case (bus.mem_wr_sel)
         2'd1: begin
            wr_be    = 4'b0001 << bus.mem_wr_addr[1:0];
            wr_lanes = {4{bus.mem_wr_data[7:0]}};
         end
         2'd2: begin
            wr_be    = bus.mem_wr_addr[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{bus.mem_wr_data[15:0]}};
         end
         2'd3:    wr_be = 4'b1111;
         default: wr_be = 4'b0000;
      endcase
   end

   // A store sampled while reset is asserted must not reach the array.
   assign wr_req = rst && idle && bus.mem_wr_en && (bus.mem_wr_sel != 2'd0);
   assign wr_go  = wr_req && !wr_oor;

   always_ff @(posedge clk) begin
      if (wr_go) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
         end
      end
   end

   // Line as it will look after this edge, so a same-edge store is included.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         rd_line[32*k +: 32] = mem[line_base | AW'(k)];
         for (int b = 0; b < 4; b++) begin
            if (wr_go && wr_be[b] && (wr_idx == (line_base | AW'(k)))) begin
               rd_line[32*k + 8*b +: 8] = wr_lanes[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         base_q    <= '0;
         rd_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         if (load_line) rd_data_q <= line_oor ? '0 : rd_line;
      end
   end

`ifdef MEM_RESP_RANGE_CHECK_EN
   logic rd_oor_now, rd_oor_q, err_q;

   assign rd_oor_now = (bus.mem_rd_addr >> (AW + 2)) != 32'd0;
   assign wr_oor     = (bus.mem_wr_addr >> (AW + 2)) != 32'd0;
   assign line_oor   = idle ? rd_oor_now : rd_oor_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_oor_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (idle && bus.mem_rd_en) rd_oor_q <= rd_oor_now;
         err_q <= (wr_req && wr_oor) || (load_line && line_oor);
      end
   end

   assign bus.mem_err = err_q;
`else
   assign wr_oor   = 1'b0;
   assign line_oor = 1'b0;
`endif

   assign bus.mem_rd_data  = rd_data_q;
   assign bus.mem_rd_valid = (state_q == RD_RESP);
   assign bus.mem_busy     = !idle;
endmodule
